// File: rtl/axi_stream_demux_1to2.sv
// 1-to-2 AXI-Stream demultiplexer with a main+skid buffer per output.
// Define AXIS_DEMUX_PKT_LOCK_EN to hold the route for a whole packet (up to tlast).
module axi_stream_demux_1to2 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [DATA_W-1:0] tdata_in,
    input  logic              tvalid_in,
    input  logic              tlast_in,
    output logic              tready_in,
    output logic [DATA_W-1:0] tdata_0,
    output logic [DATA_W-1:0] tdata_1,
    output logic              tvalid_0,
    output logic              tvalid_1,
    output logic              tlast_0,
    output logic              tlast_1,
    input  logic              tready_0,
    input  logic              tready_1,
    output logic              busy
);

    localparam int unsigned NOUT = 2;

    logic [NOUT-1:0]   main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [NOUT-1:0]   main_last_q, main_last_d, skid_last_q, skid_last_d;
    logic [DATA_W-1:0] main_data_q [NOUT];
    logic [DATA_W-1:0] main_data_d [NOUT];
    logic [DATA_W-1:0] skid_data_q [NOUT];
    logic [DATA_W-1:0] skid_data_d [NOUT];
    logic [NOUT-1:0]   rdy_q;
    logic [NOUT-1:0]   xfer_c;
    logic [NOUT-1:0]   load_c;
    logic              route_c;
    logic              accept_c;

    assign xfer_c    = main_v_q & {tready_1, tready_0};
    assign tready_in = rdy_q[route_c];
    assign accept_c  = tvalid_in & tready_in;
    assign load_c    = accept_c ? (route_c ? 2'b10 : 2'b01) : 2'b00;

`ifdef AXIS_DEMUX_PKT_LOCK_EN
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   route_q, route_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            route_q <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    // Lock on the first beat of a multi-beat packet, release on its tlast beat.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            IDLE: begin
                if (accept_c && !tlast_in) begin
                    route_d = sel;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept_c && tlast_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign route_c = (state_q == LOCKED) ? route_q : sel;
    assign busy    = (state_q == LOCKED);
`else
    assign route_c = sel;
    assign busy    = 1'b0;
`endif

    // Buffer update: skid refills main first; new beats land in main when it frees up.
    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_last_d = main_last_q;
        skid_last_d = skid_last_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        for (int c = 0; c < NOUT; c++) begin
            if (skid_v_q[c]) begin
                if (xfer_c[c]) begin
                    main_data_d[c] = skid_data_q[c];
                    main_last_d[c] = skid_last_q[c];
                    skid_v_d[c]    = 1'b0;
                end
            end else if (load_c[c]) begin
                if (!main_v_q[c] || xfer_c[c]) begin
                    main_v_d[c]    = 1'b1;
                    main_data_d[c] = tdata_in;
                    main_last_d[c] = tlast_in;
                end else begin
                    skid_v_d[c]    = 1'b1;
                    skid_data_d[c] = tdata_in;
                    skid_last_d[c] = tlast_in;
                end
            end else if (xfer_c[c]) begin
                main_v_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q    <= '0;
            skid_v_q    <= '0;
            main_last_q <= '0;
            skid_last_q <= '0;
            rdy_q       <= '0;
            for (int c = 0; c < NOUT; c++) begin
                main_data_q[c] <= '0;
                skid_data_q[c] <= '0;
            end
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_last_q <= main_last_d;
            skid_last_q <= skid_last_d;
            rdy_q       <= ~skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign tvalid_0 = main_v_q[0];
    assign tvalid_1 = main_v_q[1];
    assign tdata_0  = main_data_q[0];
    assign tdata_1  = main_data_q[1];
    assign tlast_0  = main_last_q[0];
    assign tlast_1  = main_last_q[1];

endmodule

// File: tb/tb_axi_stream_demux_1to2.sv
// Directed self-checking bench for axi_stream_demux_1to2; follows AXIS_DEMUX_PKT_LOCK_EN
// so the packet-lock expectations match the build under test.
module tb_axi_stream_demux_1to2;

    localparam int unsigned DATA_W = 32;
`ifdef AXIS_DEMUX_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              sel;
    logic [DATA_W-1:0] tdata_in;
    logic              tvalid_in;
    logic              tlast_in;
    logic              tready_in;
    logic [DATA_W-1:0] tdata_0;
    logic [DATA_W-1:0] tdata_1;
    logic              tvalid_0;
    logic              tvalid_1;
    logic              tlast_0;
    logic              tlast_1;
    logic              tready_0;
    logic              tready_1;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    axi_stream_demux_1to2 #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .tdata_in (tdata_in),
        .tvalid_in(tvalid_in),
        .tlast_in (tlast_in),
        .tready_in(tready_in),
        .tdata_0  (tdata_0),
        .tdata_1  (tdata_1),
        .tvalid_0 (tvalid_0),
        .tvalid_1 (tvalid_1),
        .tlast_0  (tlast_0),
        .tlast_1  (tlast_1),
        .tready_0 (tready_0),
        .tready_1 (tready_1),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_W-1:0] d, input logic l);
        tvalid_in = 1'b1;
        tdata_in  = d;
        tlast_in  = l;
    endtask

    task automatic idle();
        tvalid_in = 1'b0;
        tlast_in  = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; tdata_in = '0; tvalid_in = 1'b0; tlast_in = 1'b0;
        tready_0 = 1'b0; tready_1 = 1'b0;
        repeat (2) step();
        chk1("rst_tvalid_0", tvalid_0, 1'b0);
        chk1("rst_tvalid_1", tvalid_1, 1'b0);
        chkd("rst_tdata_0", tdata_0, '0);
        chkd("rst_tdata_1", tdata_1, '0);
        chk1("rst_tlast_0", tlast_0, 1'b0);
        chk1("rst_tlast_1", tlast_1, 1'b0);
        chk1("rst_tready_in", tready_in, 1'b0);
        chk1("rst_busy", busy, 1'b0);

        rst_n = 1'b1;
        #1;
        chk1("rel_tready_before_e1", tready_in, 1'b0);
        step();
        chk1("rel_tready_after_e1", tready_in, 1'b1);

        // Streaming A0..A3 into output 0 at full rate
        tready_0 = 1'b1; sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(DATA_W'(32'hA0 + i), (i == 3));
            step();
            chk1("a_tvalid_0", tvalid_0, 1'b1);
            chkd("a_tdata_0", tdata_0, DATA_W'(32'hA0 + i));
            chk1("a_tvalid_1", tvalid_1, 1'b0);
        end
        chk1("a_tlast_0", tlast_0, 1'b1);
        idle();
        step();
        chk1("a_drained", tvalid_0, 1'b0);

        // Output 1 stalled: main + skid fill, then in-order drain
        tready_1 = 1'b0; sel = 1'b1;
        drive(32'hB0, 1'b0);
        #1;
        chk1("b_tready_start", tready_in, 1'b1);
        step();
        chk1("b0_tvalid_1", tvalid_1, 1'b1);
        chkd("b0_tdata_1", tdata_1, 32'hB0);
        chk1("b0_tready_in", tready_in, 1'b1);
        drive(32'hB1, 1'b0);
        step();
        chk1("b1_tready_in", tready_in, 1'b0);
        chkd("b1_tdata_1", tdata_1, 32'hB0);
        drive(32'hB2, 1'b1);
        step();
        chk1("b2_stall_tready_in", tready_in, 1'b0);
        chkd("b2_stall_tdata_1", tdata_1, 32'hB0);
        chk1("b2_stall_tvalid_0", tvalid_0, 1'b0);
        tready_1 = 1'b1;
        step();
        chkd("b_drain1_tdata_1", tdata_1, 32'hB1);
        chk1("b_drain1_tready_in", tready_in, 1'b1);
        step();
        chkd("b_drain2_tdata_1", tdata_1, 32'hB2);
        chk1("b_drain2_tlast_1", tlast_1, 1'b1);
        idle();
        step();
        chk1("b_drained", tvalid_1, 1'b0);

        // sel flipped mid-packet
        tready_0 = 1'b1; tready_1 = 1'b1; sel = 1'b0;
        drive(32'hC0, 1'b0);
        step();
        chkd("c0_tdata_0", tdata_0, 32'hC0);
        chk1("c0_busy", busy, LOCK);
        sel = 1'b1;
        drive(32'hC1, 1'b0);
        step();
        chk1("c1_tvalid_0", tvalid_0, LOCK);
        chk1("c1_tvalid_1", tvalid_1, !LOCK);
        chkd("c1_tdata", LOCK ? tdata_0 : tdata_1, 32'hC1);
        chk1("c1_busy", busy, LOCK);
        drive(32'hC2, 1'b1);
        step();
        chk1("c2_tvalid_0", tvalid_0, LOCK);
        chk1("c2_tvalid_1", tvalid_1, !LOCK);
        chkd("c2_tdata", LOCK ? tdata_0 : tdata_1, 32'hC2);
        chk1("c2_tlast", LOCK ? tlast_0 : tlast_1, 1'b1);
        chk1("c2_busy", busy, 1'b0);
        drive(32'hD0, 1'b1);
        step();
        chk1("d0_tvalid_1", tvalid_1, 1'b1);
        chkd("d0_tdata_1", tdata_1, 32'hD0);
        chk1("d0_tvalid_0", tvalid_0, 1'b0);
        chk1("d0_busy", busy, 1'b0);
        idle();
        step();
        chk1("d_drained", tvalid_1, 1'b0);

        // Output 0 stalled full while output 1 streams
        tready_0 = 1'b0; tready_1 = 1'b1; sel = 1'b0;
        drive(32'hE0, 1'b0);
        step();
        chkd("e0_tdata_0", tdata_0, 32'hE0);
        chk1("e0_tready_in", tready_in, 1'b1);
        chk1("e0_busy", busy, LOCK);
        drive(32'hE1, 1'b1);
        step();
        chk1("e1_tready_in", tready_in, 1'b0);
        chk1("e1_busy", busy, 1'b0);
        sel = 1'b1;
        #1;
        chk1("f_tready_in_sel1", tready_in, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(DATA_W'(32'hF0 + i), (i == 2));
            step();
            chk1("f_tvalid_1", tvalid_1, 1'b1);
            chkd("f_tdata_1", tdata_1, DATA_W'(32'hF0 + i));
            chk1("f_tvalid_0", tvalid_0, 1'b1);
            chkd("f_tdata_0_held", tdata_0, 32'hE0);
        end
        idle();
        step();
        chk1("f_drained", tvalid_1, 1'b0);
        chkd("f_tdata_0_still", tdata_0, 32'hE0);

        // Both outputs full, reset mid-packet
        tready_1 = 1'b0;
        drive(32'h60, 1'b0);
        step();
        drive(32'h61, 1'b0);
        step();
        chk1("g_tvalid_0", tvalid_0, 1'b1);
        chk1("g_tvalid_1", tvalid_1, 1'b1);
        chk1("g_tready_in", tready_in, 1'b0);
        chk1("g_busy", busy, LOCK);
        idle();
        rst_n = 1'b0;
        #1;
        chk1("r_tvalid_0", tvalid_0, 1'b0);
        chk1("r_tvalid_1", tvalid_1, 1'b0);
        chk1("r_busy", busy, 1'b0);
        chk1("r_tready_in", tready_in, 1'b0);
        chkd("r_tdata_1", tdata_1, '0);
        step();
        rst_n = 1'b1;
        #1;
        chk1("r_rel_tready_before", tready_in, 1'b0);
        step();
        chk1("r_rel_tready_after", tready_in, 1'b1);
        chk1("r_rel_tvalid_0", tvalid_0, 1'b0);

        tready_0 = 1'b1; sel = 1'b0;
        drive(32'h77, 1'b1);
        step();
        chkd("h_tdata_0", tdata_0, 32'h77);
        chk1("h_tvalid_1", tvalid_1, 1'b0);
        idle();
        step();
        chk1("h_drained", tvalid_0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
